// File: rtl/alu_pkg.sv
// Shared constants for the clocked ALU: function codes,
// control states and divide-by-zero result values.
package alu_pkg;

  localparam logic [4:0] FC_ADD  = 5'b00000;
  localparam logic [4:0] FC_SUB  = 5'b00001;
  localparam logic [4:0] FC_MUL  = 5'b00010;
  localparam logic [4:0] FC_SQRT = 5'b00011;
  localparam logic [4:0] FC_DIV  = 5'b00100;
  localparam logic [4:0] FC_MOD  = 5'b00101;
  localparam logic [4:0] FC_SHL  = 5'b00110;
  localparam logic [4:0] FC_SHR  = 5'b00111;
  localparam logic [4:0] FC_ROL  = 5'b01000;
  localparam logic [4:0] FC_ROR  = 5'b01001;
  localparam logic [4:0] FC_EQ   = 5'b10000;
  localparam logic [4:0] FC_NE   = 5'b10001;
  localparam logic [4:0] FC_GT   = 5'b10010;
  localparam logic [4:0] FC_GE   = 5'b10011;
  localparam logic [4:0] FC_LT   = 5'b10100;
  localparam logic [4:0] FC_LE   = 5'b10101;
  localparam logic [4:0] FC_NOT  = 5'b11000;
  localparam logic [4:0] FC_AND  = 5'b11001;
  localparam logic [4:0] FC_OR   = 5'b11010;
  localparam logic [4:0] FC_XOR  = 5'b11011;
  localparam logic [4:0] FC_XNOR = 5'b11100;

  typedef enum logic {
    LEERLAUF = 1'b0,
    RECHNEN  = 1'b1
  } zustand_t;

  // x/0 yields a quotient of all ones (this bit replicated);
  // x%0 yields the dividend unchanged.
  localparam bit DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/alu_seriell_teiler.sv
// Signed restoring divider, one quotient bit per clock.
// Result appears combinationally alongside done_o.
module alu_seriell_teiler
  import alu_pkg::*;
#(
  parameter int BREITE = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BREITE-1:0] dividend_i,
  input  logic [BREITE-1:0] divisor_i,
  output logic              done_o,
  output logic [BREITE-1:0] quotient_o,
  output logic [BREITE-1:0] remainder_o,
  output logic              div_zero_o
);

  localparam int CW = $clog2(BREITE);
  localparam logic [CW-1:0] LETZT = CW'(BREITE-1);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [BREITE-1:0] rem_q;
  logic [BREITE-1:0] quo_q;
  logic [BREITE-1:0] dvs_q;
  logic [BREITE-1:0] dividend_q;
  logic              negq_q;
  logic              zero_q;

  logic [BREITE:0]   sh;
  logic              ge;
  logic [BREITE-1:0] rem_d;
  logic [BREITE-1:0] quo_d;

  function automatic logic [BREITE-1:0] betrag(
    input logic [BREITE-1:0] x
  );
    return x[BREITE-1] ? -x : x;
  endfunction

  // One restoring step on the unsigned magnitudes
  always_comb begin
    sh    = {rem_q, quo_q[BREITE-1]};
    ge    = sh >= {1'b0, dvs_q};
    rem_d = BREITE'(ge ? sh - {1'b0, dvs_q} : sh);
    quo_d = BREITE'({quo_q, ge});
  end

  assign done_o     = busy_q && (cnt_q == LETZT);
  assign div_zero_o = zero_q;

  // Sign correction, with the zero-divisor override
  always_comb begin
    if (zero_q) begin
      quotient_o  = {BREITE{DIV0_QUOT_BIT}};
      remainder_o = dividend_q;
    end else begin
      quotient_o  = negq_q ? -quo_d : quo_d;
      remainder_o = dividend_q[BREITE-1] ? -rem_d : rem_d;
    end
  end

  // Operand capture and iteration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      negq_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else if (start_i) begin
      busy_q     <= 1'b1;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= betrag(dividend_i);
      dvs_q      <= betrag(divisor_i);
      dividend_q <= dividend_i;
      negq_q     <= dividend_i[BREITE-1]
                  ^ divisor_i[BREITE-1];
      zero_q     <= (divisor_i == '0);
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequenziell.sv
// Clocked ALU with Start/Bereit/Fertig handshake.
// Macro ALU_SQRT_EN builds the serial square-root unit.
module alu_sequenziell
  import alu_pkg::*;
#(
  parameter int BREITE    = 32,
  parameter int FC_BREITE = 6
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [BREITE-1:0]    Daten1,
  input  logic [BREITE-1:0]    Daten2,
  input  logic [FC_BREITE-1:0] FunktionsCode,
  output logic                 Bereit,
  output logic [BREITE-1:0]    Ergebnis,
  output logic                 Fertig,
  output logic                 Fehler
);

  localparam int AW = $clog2(BREITE);

  zustand_t          zustand_q;
  logic [4:0]        op_q;
  logic [BREITE-1:0] erg_q;
  logic              fertig_q;
  logic              fehler_q;

  logic [4:0]          op;
  logic [BREITE-1:0]   res_c;
  logic                err_c;
  logic                multi_c;
  logic                cmp_c;
  logic [AW-1:0]       amt;
  logic [2*BREITE-1:0] dbl;

  logic              div_start;
  logic              div_done;
  logic [BREITE-1:0] div_quot;
  logic [BREITE-1:0] div_rest;
  logic              div_zero;

`ifdef ALU_SQRT_EN
  localparam int CW = $clog2(BREITE/2);
  localparam logic [CW-1:0] SQ_LETZT = CW'(BREITE/2-1);
  logic [CW-1:0]     cnt_q;
  logic [BREITE-1:0] rad_q;
  logic [BREITE-1:0] srem_q;
  logic [BREITE-1:0] root_q;
  logic [BREITE+1:0] sq_sh;
  logic [BREITE+1:0] sq_trial;
  logic              sq_ge;
  logic [BREITE-1:0] srem_d;
  logic [BREITE-1:0] root_d;

  // One shift-subtract root digit per clock
  always_comb begin
    sq_sh    = {srem_q, rad_q[BREITE-1:BREITE-2]};
    sq_trial = {root_q, 2'b01};
    sq_ge    = sq_sh >= sq_trial;
    srem_d   = BREITE'(sq_ge ? sq_sh - sq_trial : sq_sh);
    root_d   = BREITE'({root_q, sq_ge});
  end
`endif

  assign op  = FunktionsCode[4:0];
  assign amt = Daten2[AW-1:0];
  assign dbl = {Daten1, Daten1};

  // Single-cycle result and multi-cycle classification
  always_comb begin
    res_c   = '0;
    err_c   = 1'b0;
    multi_c = 1'b0;
    cmp_c   = 1'b0;
    if (FunktionsCode[FC_BREITE-1]) begin
      err_c = 1'b1;
    end else begin
      unique case (op)
        FC_ADD:  res_c = Daten1 + Daten2;
        FC_SUB:  res_c = Daten1 - Daten2;
        FC_MUL:  res_c = Daten1 * Daten2;
`ifdef ALU_SQRT_EN
        FC_SQRT: multi_c = 1'b1;
`else
        FC_SQRT: err_c = 1'b1;
`endif
        FC_DIV:  multi_c = 1'b1;
        FC_MOD:  multi_c = 1'b1;
        FC_SHL:  res_c = Daten1 << Daten2;
        FC_SHR:  res_c = Daten1 >> Daten2;
        FC_ROL:  res_c = BREITE'((dbl << amt) >> BREITE);
        FC_ROR:  res_c = BREITE'(dbl >> amt);
        FC_EQ:   cmp_c = Daten1 == Daten2;
        FC_NE:   cmp_c = Daten1 != Daten2;
        FC_GT:   cmp_c = Daten1 >  Daten2;
        FC_GE:   cmp_c = Daten1 >= Daten2;
        FC_LT:   cmp_c = Daten1 <  Daten2;
        FC_LE:   cmp_c = Daten1 <= Daten2;
        FC_NOT:  res_c = ~Daten1;
        FC_AND:  res_c = Daten1 & Daten2;
        FC_OR:   res_c = Daten1 | Daten2;
        FC_XOR:  res_c = Daten1 ^ Daten2;
        FC_XNOR: res_c = ~(Daten1 ^ Daten2);
        default: err_c = 1'b1;
      endcase
      if (op[4] && !op[3])
        res_c = {{(BREITE-1){1'b0}}, cmp_c};
    end
  end

  assign div_start = Start && (zustand_q == LEERLAUF)
                   && multi_c && (op != FC_SQRT);

  alu_seriell_teiler #(
    .BREITE (BREITE)
  ) u_teiler (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .start_i     (div_start),
    .dividend_i  (Daten1),
    .divisor_i   (Daten2),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rest),
    .div_zero_o  (div_zero)
  );

  // Control FSM with registered result and status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q <= LEERLAUF;
      op_q      <= '0;
      erg_q     <= '0;
      fertig_q  <= 1'b0;
      fehler_q  <= 1'b0;
`ifdef ALU_SQRT_EN
      cnt_q     <= '0;
      rad_q     <= '0;
      srem_q    <= '0;
      root_q    <= '0;
`endif
    end else begin
      fertig_q <= 1'b0;
      unique case (zustand_q)
        LEERLAUF: begin
          if (Start) begin
            if (multi_c) begin
              zustand_q <= RECHNEN;
              op_q      <= op;
`ifdef ALU_SQRT_EN
              cnt_q  <= '0;
              rad_q  <= Daten1;
              srem_q <= '0;
              root_q <= '0;
`endif
            end else begin
              erg_q    <= res_c;
              fehler_q <= err_c;
              fertig_q <= 1'b1;
            end
          end
        end
        RECHNEN: begin
`ifdef ALU_SQRT_EN
          if (op_q == FC_SQRT) begin
            cnt_q  <= cnt_q + 1'b1;
            rad_q  <= rad_q << 2;
            srem_q <= srem_d;
            root_q <= root_d;
            if (cnt_q == SQ_LETZT) begin
              erg_q     <= root_d;
              fehler_q  <= 1'b0;
              fertig_q  <= 1'b1;
              zustand_q <= LEERLAUF;
            end
          end else
`endif
          if (div_done) begin
            erg_q     <= (op_q == FC_DIV) ? div_quot
                                          : div_rest;
            fehler_q  <= div_zero;
            fertig_q  <= 1'b1;
            zustand_q <= LEERLAUF;
          end
        end
        default: zustand_q <= LEERLAUF;
      endcase
    end
  end

  assign Bereit   = (zustand_q == LEERLAUF);
  assign Ergebnis = erg_q;
  assign Fertig   = fertig_q;
  assign Fehler   = fehler_q;

endmodule

// File: tb/tb_alu_sequenziell.sv
// Directed bench for alu_sequenziell: handshake timing,
// arithmetic, shifts, error cases and reset abort.
module tb_alu_sequenziell;

  localparam logic [5:0] C_ADD  = 6'h00;
  localparam logic [5:0] C_SUB  = 6'h01;
  localparam logic [5:0] C_MUL  = 6'h02;
  localparam logic [5:0] C_SQRT = 6'h03;
  localparam logic [5:0] C_DIV  = 6'h04;
  localparam logic [5:0] C_MOD  = 6'h05;
  localparam logic [5:0] C_SHL  = 6'h06;
  localparam logic [5:0] C_SHR  = 6'h07;
  localparam logic [5:0] C_ROL  = 6'h08;
  localparam logic [5:0] C_ROR  = 6'h09;
  localparam logic [5:0] C_GT   = 6'h12;
  localparam logic [5:0] C_LT   = 6'h14;
  localparam logic [5:0] C_NOT  = 6'h18;
  localparam logic [5:0] C_XNOR = 6'h1C;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [5:0]  fc;
  logic        bereit;
  logic [31:0] erg;
  logic        fertig;
  logic        fehler;

  int total = 0;
  int bad   = 0;

  alu_sequenziell #(
    .BREITE    (32),
    .FC_BREITE (6)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .Start         (start),
    .Daten1        (d1),
    .Daten2        (d2),
    .FunktionsCode (fc),
    .Bereit        (bereit),
    .Ergebnis      (erg),
    .Fertig        (fertig),
    .Fehler        (fehler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag,
                        input logic [5:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input logic expf);
    fc = f; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_fertig"}, 32'(fertig), 32'd1);
    chk({tag, "_erg"}, erg, exp);
    chk({tag, "_fehler"}, 32'(fehler), 32'(expf));
  endtask

  task automatic multi(input string tag,
                       input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int lat,
                       input logic [31:0] exp,
                       input logic expf,
                       input bit poke);
    int k;
    fc = f; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    k = 1;
    start = 1'b0;
    d1 = $urandom;
    d2 = $urandom;
    fc = C_ADD;
    chk({tag, "_busy"}, 32'(bereit), 32'd0);
    while (!fertig && k < 100) begin
      start = poke && (k == 5);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_erg"}, erg, exp);
    chk({tag, "_fehler"}, 32'(fehler), 32'(expf));
    chk({tag, "_bereit"}, 32'(bereit), 32'd1);
    @(negedge clk);
    chk({tag, "_nopulse"}, 32'(fertig), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    d1 = '0; d2 = '0; fc = '0;
    repeat (2) @(negedge clk);
    chk("rst_erg", erg, 32'h0);
    chk("rst_fertig", 32'(fertig), 32'd0);
    chk("rst_fehler", 32'(fehler), 32'd0);
    chk("rst_bereit", 32'(bereit), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back ADD then SUB
    fc = C_ADD; d1 = 32'h7FFFFFFF; d2 = 32'h1;
    start = 1'b1;
    @(negedge clk);
    chk("add_fertig", 32'(fertig), 32'd1);
    chk("add_erg", erg, 32'h80000000);
    chk("add_bereit", 32'(bereit), 32'd1);
    fc = C_SUB; d1 = 32'd5; d2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("sub_fertig", 32'(fertig), 32'd1);
    chk("sub_erg", erg, 32'hFFFFFFFE);
    chk("sub_bereit", 32'(bereit), 32'd1);
    @(negedge clk);
    chk("idle_fertig", 32'(fertig), 32'd0);

    // serial divider
    multi("div", C_DIV, 32'hFFFFFFF9, 32'd2,
          33, 32'hFFFFFFFD, 1'b0, 1'b1);
    multi("mod", C_MOD, 32'hFFFFFFF9, 32'd2,
          33, 32'hFFFFFFFF, 1'b0, 1'b0);
    multi("div0", C_DIV, 32'd10, 32'd0,
          33, 32'hFFFFFFFF, 1'b1, 1'b0);
    multi("mod0", C_MOD, 32'd10, 32'd0,
          33, 32'h0000000A, 1'b1, 1'b0);
    multi("divmin", C_DIV, 32'h80000000, 32'hFFFFFFFF,
          33, 32'h80000000, 1'b0, 1'b0);
    multi("modmin", C_MOD, 32'h80000000, 32'hFFFFFFFF,
          33, 32'h0, 1'b0, 1'b0);
    multi("div100", C_DIV, 32'd100, 32'hFFFFFFF9,
          33, 32'hFFFFFFF2, 1'b0, 1'b0);

    // square root
`ifdef ALU_SQRT_EN
    multi("sqrtmax", C_SQRT, 32'hFFFFFFFF, 32'h0,
          17, 32'h0000FFFF, 1'b0, 1'b0);
    multi("sqrt17", C_SQRT, 32'd17, 32'h0,
          17, 32'd4, 1'b0, 1'b1);
`else
    single("sqrtoff", C_SQRT, 32'd17, 32'h0,
           32'h0, 1'b1);
`endif

    // shifts, rotates, logic, compares, errors
    single("shl32", C_SHL, 32'h1, 32'd32, 32'h0, 1'b0);
    single("shl4", C_SHL, 32'h1, 32'd4, 32'h10, 1'b0);
    single("shr31", C_SHR, 32'h80000000, 32'd31,
           32'h1, 1'b0);
    single("rol1", C_ROL, 32'h80000001, 32'd1,
           32'h3, 1'b0);
    single("ror33", C_ROR, 32'h3, 32'd33,
           32'h80000001, 1'b0);
    single("mul", C_MUL, 32'hFFFFFFFF, 32'd3,
           32'hFFFFFFFD, 1'b0);
    single("gt", C_GT, 32'd5, 32'd3, 32'h1, 1'b0);
    single("lt", C_LT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
    single("not", C_NOT, 32'h0F0F0000, 32'h0,
           32'hF0F0FFFF, 1'b0);
    single("xnor", C_XNOR, 32'hFF00FF00, 32'h0F0F0F0F,
           32'h0FF00FF0, 1'b0);
    single("fc20", 6'h20, 32'd1, 32'd2, 32'h0, 1'b1);
    single("fc0a", 6'h0A, 32'd1, 32'd2, 32'h0, 1'b1);

    // reset aborts a running division
    fc = C_DIV; d1 = 32'd100; d2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", 32'(bereit), 32'd0);
    rst = 1'b1;
    start = 1'b1; fc = C_ADD; d1 = 32'd2; d2 = 32'd3;
    @(negedge clk);
    chk("abort_fertig", 32'(fertig), 32'd0);
    chk("abort_erg", erg, 32'h0);
    chk("abort_bereit", 32'(bereit), 32'd1);
    chk("abort_fehler", 32'(fehler), 32'd0);
    @(negedge clk);
    chk("abort_fertig2", 32'(fertig), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("post_fertig", 32'(fertig), 32'd1);
    chk("post_erg", erg, 32'd5);
    repeat (40) begin
      @(negedge clk);
      chk("post_quiet", 32'(fertig), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
